// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate ops).
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MADD  = 3'd4;
   localparam logic [2:0] MDU_MADDU = 3'd5;

   // Quotient reported on divide-by-zero (sliced to DATA_W, which must be <= 64)
   localparam logic [63:0] DIV_BY_ZERO_LO = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_e;

   // Op codes that launch an operation in this build
   function automatic logic op_valid(input logic [2:0] op);
`ifdef MDU_MADD_EN
      return (op <= MDU_MADDU);
`else
      return (op <= MDU_DIVU);
`endif
   endfunction

   // Ops whose operands are two's-complement
   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared iterative datapath: shift-add multiply or restoring shift-subtract
// divide on unsigned magnitudes, one step per cycle, plus step counter.
// Multiply: {acc_hi,acc_lo} = a * b.  Divide: acc_lo = a / b, acc_hi = a % b.
module mdu_iter_core #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic              div_sel,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] acc_hi,
   output logic [DATA_W-1:0] acc_lo,
   output logic              last_c
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] opnd_q;
   logic              div_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [DATA_W:0]   add_sum;
   logic [DATA_W:0]   shifted;
   logic [DATA_W+1:0] sub_diff;
   logic [DATA_W-1:0] hi_d;
   logic [DATA_W-1:0] lo_d;

   assign last_c = (cnt_q == CNT_W'(DATA_W - 1));

   // One multiply or divide step computed from the current accumulator
   always_comb begin
      add_sum  = {1'b0, acc_hi} + {1'b0, opnd_q};
      shifted  = {acc_hi, acc_lo[DATA_W-1]};
      sub_diff = {1'b0, shifted} - {2'b00, opnd_q};
      hi_d     = acc_hi;
      lo_d     = acc_lo;
      if (div_q) begin
         if (sub_diff[DATA_W+1]) begin
            hi_d = shifted[DATA_W-1:0];
            lo_d = {acc_lo[DATA_W-2:0], 1'b0};
         end else begin
            hi_d = sub_diff[DATA_W-1:0];
            lo_d = {acc_lo[DATA_W-2:0], 1'b1};
         end
      end else begin
         if (acc_lo[0]) begin
            {hi_d, lo_d} = {add_sum, acc_lo[DATA_W-1:1]};
         end else begin
            {hi_d, lo_d} = {1'b0, acc_hi, acc_lo[DATA_W-1:1]};
         end
      end
   end

   // Accumulator, operand and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hi <= '0;
         acc_lo <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
      end else if (load) begin
         acc_hi <= '0;
         acc_lo <= div_sel ? a : b;
         opnd_q <= div_sel ? b : a;
         div_q  <= div_sel;
         cnt_q  <= '0;
      end else if (step) begin
         acc_hi <= hi_d;
         acc_lo <= lo_d;
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into {hi,lo}).
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              mthi,
   input  logic              mtlo,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   mdu_state_e state_q, state_d;

   logic              is_div_q, is_div_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              b_zero_q, b_zero_d;
`ifdef MDU_MADD_EN
   logic              madd_q, madd_d;
`endif
   logic [DATA_W-1:0] hi_d, lo_d;
   logic              busy_d, done_d;

   logic              a_neg, b_neg, op_div;
   logic [DATA_W-1:0] mag_a, mag_b;
   logic              core_load, core_step, core_last;
   logic [DATA_W-1:0] core_hi, core_lo;

   logic [2*DATA_W-1:0] prod_mag, prod_signed, prod_final;
   logic [DATA_W-1:0]   quo, rem;

   // Operand magnitudes and sign flags for the incoming op
   always_comb begin
      a_neg  = op_is_signed(op) & rs_data[DATA_W-1];
      b_neg  = op_is_signed(op) & rt_data[DATA_W-1];
      op_div = op_is_div(op);
      mag_a  = a_neg ? -rs_data : rs_data;
      mag_b  = b_neg ? -rt_data : rt_data;
   end

   mdu_iter_core #(.DATA_W(DATA_W)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (core_load),
      .step    (core_step),
      .div_sel (op_div),
      .a       (mag_a),
      .b       (mag_b),
      .acc_hi  (core_hi),
      .acc_lo  (core_lo),
      .last_c  (core_last)
   );

   // Sign correction of the unsigned core results
   always_comb begin
      prod_mag    = {core_hi, core_lo};
      prod_signed = neg_res_q ? -prod_mag : prod_mag;
`ifdef MDU_MADD_EN
      prod_final  = madd_q ? ({hi, lo} + prod_signed) : prod_signed;
`else
      prod_final  = prod_signed;
`endif
      quo = neg_res_q ? -core_lo : core_lo;
      rem = neg_rem_q ? -core_hi : core_hi;
   end

   // Next-state, HI/LO update and control outputs
   always_comb begin
      state_d   = state_q;
      hi_d      = hi;
      lo_d      = lo;
      busy_d    = busy;
      done_d    = 1'b0;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      b_zero_d  = b_zero_q;
`ifdef MDU_MADD_EN
      madd_d    = madd_q;
`endif
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && op_valid(op)) begin
               core_load = 1'b1;
               state_d   = RUN;
               busy_d    = 1'b1;
               is_div_d  = op_div;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               b_zero_d  = (rt_data == '0);
`ifdef MDU_MADD_EN
               madd_d    = (op == MDU_MADD) || (op == MDU_MADDU);
`endif
            end else begin
               if (mthi) hi_d = rs_data;
               if (mtlo) lo_d = rs_data;
            end
         end
         RUN: begin
            core_step = 1'b1;
            if (core_last) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (is_div_q) begin
               // On divide-by-zero the core leaves |rs| as remainder, so
               // sign-correcting it restores the original rs_data.
               hi_d = rem;
               lo_d = b_zero_q ? DIV_BY_ZERO_LO[DATA_W-1:0] : quo;
            end else begin
               {hi_d, lo_d} = prod_final;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, HI/LO and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_zero_q  <= 1'b0;
`ifdef MDU_MADD_EN
         madd_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         hi        <= hi_d;
         lo        <= lo_d;
         busy      <= busy_d;
         done      <= done_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         b_zero_q  <= b_zero_d;
`ifdef MDU_MADD_EN
         madd_q    <= madd_d;
`endif
      end
   end

endmodule
